// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder sequencer around a single one-bit
// full-adder cell. A start request captures a_in, b_in and cin. The block then
// steps the cell LSB-first for WIDTH cycles, with the carry held in a flop, and
// presents {cout, sum_out} together with a one-cycle done pulse.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add the 'sub' input. With
// sub=1 the block computes a_in - b_in, and cout=1 means no borrow.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request, sampled only in IDLE or DONE
//   sub      (SERIAL_ADDER_SUB_EN only) subtract select, captured with operands
//   a_in     operand A, captured on the accepting edge
//   b_in     operand B, captured on the accepting edge
//   cin      carry-in, captured on the accepting edge
//   busy     high while the operation runs
//   done     one-cycle pulse when sum_out/cout are updated
//   sum_out  result register, held until the next result
//   cout     final carry-out, held with sum_out
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout
);

   localparam int unsigned CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   // The accumulator holds only the low WIDTH-1 sum bits. The final sum bit
   // goes straight into sum_out on the last step.
   localparam int unsigned SSW = WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [SSW-1:0]   ss_q, ss_d;
   logic             c_q, c_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_d;
   logic             cout_d;
   logic             busy_d;
   logic             done_d;
   logic             accept;
   logic             fa_s;
   logic             fa_co;

   // Shared one-bit full-adder cell
   always_comb begin
      fa_s  = sa_q[0] ^ sb_q[0] ^ c_q;
      fa_co = (sa_q[0] & sb_q[0]) | (c_q & (sa_q[0] ^ sb_q[0]));
   end

   // Next-state, datapath and output logic
   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      ss_d    = ss_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_out;
      cout_d  = cout;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      accept  = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            accept  = start;
         end
         RUN: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            ss_d  = SSW'({fa_s, ss_q} >> 1);
            c_d   = fa_co;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               sum_d   = {fa_s, ss_q};
               cout_d  = fa_co;
               done_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               busy_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Accept from IDLE or DONE: capture operands and restart the count
      if (accept) begin
         state_d = RUN;
         busy_d  = 1'b1;
         sa_d    = a_in;
         ss_d    = '0;
         cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
         // Subtract as A + ~B + 1
         sb_d    = sub ? ~b_in : b_in;
         c_d     = sub ? 1'b1 : cin;
`else
         sb_d    = b_in;
         c_d     = cin;
`endif
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         ss_q    <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_out <= '0;
         cout    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         ss_q    <= ss_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_out <= sum_d;
         cout    <= cout_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

endmodule
